instruction_fetcher: RTL
========================

# instruction_fetcher

Per-SIMD instruction fetch stage sitting directly downstream of the per-wave PC: takes the active wave's PC, issues a single read to program memory over a valid/ready request channel, captures the returned instruction and holds it for the decoder until acknowledged. Supports a flush (wave switch or new dispatch) that cancels the fetch and safely drains any response already in flight. One outstanding request at most; also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- PROGRAM_MEM_ADDR_WIDTH, 32, width of pc_in and mem_read_addr
- PROGRAM_MEM_DATA_WIDTH, 32, instruction width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- fetch_start  in  1  request fetch of pc_in; sampled only in IDLE
- flush  in  1  cancel current fetch; overrides fetch_start/instruction_ack
- pc_in  in  PROGRAM_MEM_ADDR_WIDTH  PC of active wave (from PC block pc_out)
- mem_read_valid  out  1  request valid to program memory
- mem_read_addr  out  PROGRAM_MEM_ADDR_WIDTH  request address
- mem_read_ready  in  1  memory accepts request this cycle
- mem_read_data_valid  in  1  response valid (one cycle per accepted request)
- mem_read_data  in  PROGRAM_MEM_DATA_WIDTH  response data
- instruction  out  PROGRAM_MEM_DATA_WIDTH  captured instruction
- instruction_valid  out  1  instruction held for decoder
- instruction_ack  in  1  decoder consumed instruction
- fetch_state  out  3  encoded state: IDLE=0, REQUEST=1, WAIT=2, FETCHED=3, DRAIN=4
- stall_cycles  out  16  count of cycles spent in REQUEST or WAIT, saturating

## Operation
- Priority each cycle: rst > flush > normal transitions.
- IDLE: fetch_start & !flush -> latch pc_in into mem_read_addr, go REQUEST. Otherwise stay.
- REQUEST: mem_read_valid=1. mem_read_ready -> WAIT. flush & ready -> DRAIN (request was accepted). flush & !ready -> IDLE (request withdrawn; memory permits withdrawal of unaccepted requests).
- WAIT: mem_read_data_valid -> capture mem_read_data into instruction, go FETCHED. flush & data_valid -> IDLE, data discarded, instruction unchanged. flush & !data_valid -> DRAIN.
- FETCHED: instruction_valid=1. instruction_ack -> IDLE. flush -> IDLE (instruction_valid drops; instruction register retains value).
- DRAIN: wait for mem_read_data_valid, discard it, -> IDLE. fetch_start and flush ignored in DRAIN.
- mem_read_data_valid in IDLE, REQUEST or FETCHED: ignored, no state change.
- fetch_start outside IDLE: ignored (not queued).
- mem_read_addr stable for the whole REQUEST/WAIT/DRAIN interval; changes only on IDLE->REQUEST.
- stall_cycles increments by 1 each cycle state is REQUEST or WAIT; saturates at 16'hFFFF; cleared only by rst.
- Controller pulses the PC block's UPDATE_PC in the cycle it asserts instruction_ack; this block does not drive the PC.

## Timing
- All outputs registered or decoded from the state register only; no combinational input-to-output path.
- Reset values: fetch_state=IDLE(0), mem_read_valid=0, mem_read_addr=0, instruction=0, instruction_valid=0, stall_cycles=0.
- rst asserted in any state (incl. WAIT/DRAIN with response pending) -> IDLE next cycle; subsequent stray response ignored by IDLE rule.
- fetch_start at cycle N -> mem_read_valid high at N+1.
- ready at N+1 -> WAIT at N+2; data_valid at N+2 -> instruction_valid at N+3. Minimum fetch latency 3 cycles.
- ack at cycle M -> IDLE at M+1; fetch_start at M+1 accepted, next request at M+2.
- Each cycle in REQUEST with ready low adds one cycle latency and one stall count.

## Test plan
- Basic fetch: pc_in=0x10, fetch_start 1 cycle, ready immediate, data 0xDEADBEEF one cycle after acceptance -> mem_read_addr=0x10, instruction_valid at start+3, instruction=0xDEADBEEF, stall_cycles=2; ack -> IDLE next cycle.
- Backpressure: ready low 4 cycles then high, data_valid 3 cycles later -> mem_read_valid held 5 cycles, addr constant, stall_cycles=8, correct instruction captured.
- Flush in WAIT: flush before response, response 0x1234 arrives 2 cycles later -> state DRAIN, then IDLE, instruction_valid never asserts, instruction unchanged; fetch_start during DRAIN ignored.
- Flush edge cases: flush with ready low in REQUEST -> IDLE next cycle, no DRAIN; flush same cycle as data_valid in WAIT -> IDLE, data discarded; flush in FETCHED with ack -> IDLE, instruction_valid 0.
- Reset mid-operation: rst in WAIT, then stray data_valid in IDLE -> all outputs at reset values, state stays IDLE.
- Saturation: force 70000 cycles in REQUEST (ready low) -> stall_cycles stops at 0xFFFF, no wrap.

Source files
------------

// File: rtl/instruction_fetcher.sv
// Instruction fetch stage: issues one program-memory read per fetch, holds the
// returned instruction for the decoder, drains in-flight responses on flush and
// counts request/wait stall cycles (saturating).
module instruction_fetcher #(
    parameter int unsigned PROGRAM_MEM_ADDR_WIDTH = 32,
    parameter int unsigned PROGRAM_MEM_DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              fetch_start,
    input  logic                              flush,
    input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_in,
    output logic                              mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] mem_read_addr,
    input  logic                              mem_read_ready,
    input  logic                              mem_read_data_valid,
    input  logic [PROGRAM_MEM_DATA_WIDTH-1:0] mem_read_data,
    output logic [PROGRAM_MEM_DATA_WIDTH-1:0] instruction,
    output logic                              instruction_valid,
    input  logic                              instruction_ack,
    output logic [2:0]                        fetch_state,
    output logic [15:0]                       stall_cycles
);

    localparam int unsigned STALL_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQUEST = 3'd1,
        WAIT    = 3'd2,
        FETCHED = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t                             state;
    state_t                             state_next;
    logic [PROGRAM_MEM_ADDR_WIDTH-1:0]  addr_next;
    logic [PROGRAM_MEM_DATA_WIDTH-1:0]  instr_next;
    logic [STALL_WIDTH-1:0]             stall_next;

    // Next-state, address latch, instruction capture and stall counter update
    always_comb begin
        state_next = state;
        addr_next  = mem_read_addr;
        instr_next = instruction;
        stall_next = stall_cycles;

        case (state)
            IDLE: begin
                if (fetch_start && !flush) begin
                    addr_next  = pc_in;
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                if (flush) begin
                    // Accepted request still owes a response; unaccepted one is withdrawn
                    state_next = mem_read_ready ? DRAIN : IDLE;
                end else if (mem_read_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_next = mem_read_data_valid ? IDLE : DRAIN;
                end else if (mem_read_data_valid) begin
                    instr_next = mem_read_data;
                    state_next = FETCHED;
                end
            end
            FETCHED: begin
                if (flush || instruction_ack) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (mem_read_data_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if ((state == REQUEST || state == WAIT) && (stall_cycles != {STALL_WIDTH{1'b1}})) begin
            stall_next = stall_cycles + STALL_WIDTH'(1);
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            mem_read_valid    <= 1'b0;
            mem_read_addr     <= '0;
            instruction       <= '0;
            instruction_valid <= 1'b0;
            stall_cycles      <= '0;
        end else begin
            state             <= state_next;
            mem_read_valid    <= (state_next == REQUEST);
            mem_read_addr     <= addr_next;
            instruction       <= instr_next;
            instruction_valid <= (state_next == FETCHED);
            stall_cycles      <= stall_next;
        end
    end

    assign fetch_state = state;

endmodule
